// File: rtl/lcms_dac_update_scheduler.sv
// Round-robin scheduler that writes changed or forced bias/reference DAC channels
// to the DAC1/DAC2 serial engine, one word per valid/ready + done exchange.
module lcms_dac_update_scheduler #(
    parameter int NUM_CH     = 11,
    parameter int CH_PER_DAC = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 dac_sm_clk,
    input  logic                 reset,
    input  logic [NUM_CH*16-1:0] ch_data_i,
    input  logic                 force_refresh_i,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic                 wr_dac_sel_o,
    output logic [2:0]           wr_addr_o,
    output logic [15:0]          wr_data_o,
    input  logic                 wr_done_i,
    output logic                 busy_o,
    output logic [NUM_CH-1:0]    pending_o,
    output logic                 cfg_valid_o
);
    localparam int              IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W:0]  NUM_CH_W = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_DONE, GAP} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [15:0]       shadow_reg [NUM_CH];
    logic [15:0]       ch_word    [NUM_CH];
    logic [NUM_CH-1:0] force_reg;
    logic [NUM_CH-1:0] written_reg;
    logic [NUM_CH-1:0] pending;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [15:0]       data_reg;
    logic              dac_sel_reg;
    logic [2:0]        addr_reg;
    logic [7:0]        gap_cnt_reg;
    logic              cfg_valid_reg;

    logic [IDX_W:0]    cand;
    logic [IDX_W-1:0]  pick;
    logic              pick_found;
    logic              pick_sel;
    logic [2:0]        pick_addr;
    logic              handshake;
    logic              gap_done;

    // A channel is pending while its live value differs from what was last sent, or it is forced.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign ch_word[gi] = ch_data_i[16*gi +: 16];
        assign pending[gi] = (ch_word[gi] != shadow_reg[gi]) | force_reg[gi];
    end

    // First pending channel at or after the pointer, wrapping past NUM_CH-1.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(i);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end
            if (!pick_found && pending[cand[IDX_W-1:0]]) begin
                pick       = cand[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        int k;
        k         = int'(pick);
        pick_sel  = 1'(k / CH_PER_DAC);
        pick_addr = 3'(k % CH_PER_DAC);
    end

    assign handshake = (state_reg == ISSUE) && wr_ready_i;
    assign gap_done  = (gap_cnt_reg == GAP_LAST);

    always_ff @(posedge dac_sm_clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (|pending) state_next = SELECT;
            SELECT:    state_next = pick_found ? ISSUE : IDLE;
            ISSUE:     if (wr_ready_i) state_next = WAIT_DONE;
            WAIT_DONE: if (wr_done_i) state_next = GAP;
            GAP:       if (gap_done) state_next = (|pending) ? SELECT : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_valid_o = (state_reg == ISSUE);
        busy_o     = (state_reg != IDLE);
    end

    assign wr_dac_sel_o = dac_sel_reg;
    assign wr_addr_o    = addr_reg;
    assign wr_data_o    = data_reg;
    assign pending_o    = pending;
    assign cfg_valid_o  = cfg_valid_reg;

    always_ff @(posedge dac_sm_clk) begin
        if (!reset) begin
            ptr_reg       <= '0;
            idx_reg       <= '0;
            data_reg      <= '0;
            dac_sel_reg   <= 1'b0;
            addr_reg      <= '0;
            gap_cnt_reg   <= '0;
            force_reg     <= '1;
            written_reg   <= '0;
            cfg_valid_reg <= 1'b0;
        end else begin
            cfg_valid_reg <= cfg_valid_reg | (&written_reg);

            if (state_reg == SELECT && pick_found) begin
                idx_reg     <= pick;
                data_reg    <= ch_word[pick];
                dac_sel_reg <= pick_sel;
                addr_reg    <= pick_addr;
            end

            if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg + 8'd1;
            end else begin
                gap_cnt_reg <= '0;
            end

            // A refresh request landing on the accept cycle must keep the channel forced.
            if (force_refresh_i) begin
                force_reg <= '1;
            end else if (handshake) begin
                force_reg[idx_reg] <= 1'b0;
            end

            if (handshake) begin
                written_reg[idx_reg] <= 1'b1;
                ptr_reg <= (idx_reg == LAST_CH) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge dac_sm_clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (handshake) begin
            shadow_reg[idx_reg] <= data_reg;
        end
    end

endmodule

// File: tb/tb_lcms_dac_update_scheduler.sv
// Bench for lcms_dac_update_scheduler: directed scenarios with literal expectations
// plus a per-cycle scoreboard derived from the shadow/force/round-robin rules.
module tb_lcms_dac_update_scheduler;
    localparam int NUM_CH     = 11;
    localparam int CH_PER_DAC = 8;
    localparam int GAP_CYCLES = 4;
    localparam int BUS_W      = NUM_CH * 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [BUS_W-1:0]  ch_data_i = '0;
    logic              force_refresh_i = 1'b0;
    logic              wr_ready_i = 1'b1;
    logic              auto_done = 1'b0;
    logic              inj_done = 1'b0;
    logic              wr_done_i;
    logic              wr_valid_o;
    logic              wr_dac_sel_o;
    logic [2:0]        wr_addr_o;
    logic [15:0]       wr_data_o;
    logic              busy_o;
    logic [NUM_CH-1:0] pending_o;
    logic              cfg_valid_o;

    assign wr_done_i = auto_done | inj_done;

    lcms_dac_update_scheduler #(
        .NUM_CH(NUM_CH), .CH_PER_DAC(CH_PER_DAC), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .dac_sm_clk(clk), .reset(reset), .ch_data_i(ch_data_i),
        .force_refresh_i(force_refresh_i), .wr_valid_o(wr_valid_o),
        .wr_ready_i(wr_ready_i), .wr_dac_sel_o(wr_dac_sel_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_done_i(wr_done_i),
        .busy_o(busy_o), .pending_o(pending_o), .cfg_valid_o(cfg_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serializer stand-in: accepts immediately when ready, finishes 20 cycles later.
    int done_cnt = 0;
    int done_log[$];
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (!reset) begin
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt = done_cnt - 1;
                if (done_cnt == 0) begin
                    auto_done = 1'b1;
                    done_log.push_back(cyc);
                end
            end
            if (wr_valid_o && wr_ready_i) done_cnt = 20;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [15:0] ch_val [NUM_CH];

    // Scoreboard state and the log of accepted words (observed values).
    logic [15:0]       sh_m [NUM_CH];
    logic [NUM_CH-1:0] force_m;
    logic [NUM_CH-1:0] written_m;
    logic              cfg_m;
    int                ptr_m;
    logic              tx_sel[$];
    logic [2:0]        tx_addr[$];
    logic [15:0]       tx_data[$];
    int                tx_cyc[$];
    int                rise_log[$];

    function automatic logic [15:0] chv(input logic [BUS_W-1:0] bus, input int k);
        logic [BUS_W-1:0] t;
        t = bus >> (16 * k);
        return t[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_loop();
        logic [NUM_CH-1:0] pend_now;
        logic [NUM_CH-1:0] prev_pend;
        logic [BUS_W-1:0]  prev_bus;
        int                prev_ptr;
        logic              valid_prev;
        int                exp_k;
        logic [15:0]       exp_data;
        int                k;
        for (int i = 0; i < NUM_CH; i++) sh_m[i] = '0;
        force_m = '1; written_m = '0; cfg_m = 1'b0; ptr_m = 0;
        prev_pend = '0; prev_bus = '0; prev_ptr = 0; valid_prev = 1'b0;
        exp_k = -1; exp_data = '0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++)
                pend_now[i] = (chv(ch_data_i, i) != sh_m[i]) | force_m[i];
            check("pending_o", 32'(pending_o), 32'(pend_now));
            check("cfg_valid_o", 32'(cfg_valid_o), 32'(cfg_m));
            if (wr_valid_o && !valid_prev) begin
                // Selection was made in the previous cycle from that cycle's pending set.
                exp_k = -1;
                for (int i = 0; i < NUM_CH; i++) begin
                    k = (prev_ptr + i) % NUM_CH;
                    if (exp_k < 0 && prev_pend[k]) exp_k = k;
                end
                rise_log.push_back(cyc);
                if (exp_k < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL select: wr_valid_o rose with nothing pending (cycle %0d)", cyc);
                end else begin
                    exp_data = chv(prev_bus, exp_k);
                end
            end
            if (wr_valid_o && exp_k >= 0) begin
                check("wr_dac_sel_o", 32'(wr_dac_sel_o), 32'(exp_k / CH_PER_DAC));
                check("wr_addr_o", 32'(wr_addr_o), 32'(exp_k % CH_PER_DAC));
                check("wr_data_o", 32'(wr_data_o), 32'(exp_data));
            end
            valid_prev = wr_valid_o;
            prev_pend  = pend_now;
            prev_bus   = ch_data_i;
            prev_ptr   = ptr_m;
            if (!reset) begin
                for (int i = 0; i < NUM_CH; i++) sh_m[i] = '0;
                force_m = '1; written_m = '0; cfg_m = 1'b0; ptr_m = 0; exp_k = -1;
            end else begin
                cfg_m = cfg_m | (&written_m);
                if (wr_valid_o && wr_ready_i) begin
                    tx_sel.push_back(wr_dac_sel_o);
                    tx_addr.push_back(wr_addr_o);
                    tx_data.push_back(wr_data_o);
                    tx_cyc.push_back(cyc);
                    $display("write: cycle=%0d dac_sel=%0d addr=%0d data=0x%04h",
                             cyc, wr_dac_sel_o, wr_addr_o, wr_data_o);
                    if (exp_k >= 0) begin
                        sh_m[exp_k]      = exp_data;
                        force_m[exp_k]   = 1'b0;
                        written_m[exp_k] = 1'b1;
                        ptr_m            = (exp_k + 1) % NUM_CH;
                    end
                end
                if (force_refresh_i) force_m = '1;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [15:0] v);
        logic [BUS_W-1:0] m;
        logic [BUS_W-1:0] d;
        m = {{(BUS_W-16){1'b0}}, 16'hFFFF} << (16 * k);
        d = {{(BUS_W-16){1'b0}}, v} << (16 * k);
        ch_val[k] = v;
        ch_data_i = (ch_data_i & ~m) | d;
    endtask

    int quiet_cyc = 0;
    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        tick(1);
        while ((busy_o || wr_valid_o || pending_o != '0) && n < 3000) begin
            tick(1);
            n++;
        end
        quiet_cyc = cyc;
        check({name, "_idle_reached"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_accept(input int base, input string name);
        int n;
        n = 0;
        while (tx_sel.size() <= base && n < 200) begin
            tick(1);
            n++;
        end
        check({name, "_accept_seen"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base, input int n_exp, input int k0);
        int k;
        check({tag, "_count"}, 32'(tx_sel.size() - base), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (base + i < tx_sel.size()) begin
                k = (k0 + i) % NUM_CH;
                check($sformatf("%s_sel[%0d]", tag, i), 32'(tx_sel[base+i]), 32'(k / CH_PER_DAC));
                check($sformatf("%s_addr[%0d]", tag, i), 32'(tx_addr[base+i]), 32'(k % CH_PER_DAC));
                check($sformatf("%s_data[%0d]", tag, i), 32'(tx_data[base+i]), 32'(ch_val[k]));
            end
        end
    endtask

    task automatic run_tests();
        int base;
        int rbase;
        int dbase;
        int c0;
        int stable;
        for (int i = 0; i < NUM_CH; i++) ch_val[i] = '0;

        // Reset state and the full initial load.
        tick(3);
        check("rst_valid", 32'(wr_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cfg", 32'(cfg_valid_o), 32'd0);
        check("rst_sel", 32'(wr_dac_sel_o), 32'd0);
        check("rst_addr", 32'(wr_addr_o), 32'd0);
        check("rst_data", 32'(wr_data_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'h7FF);
        base = tx_sel.size();
        reset = 1'b1;
        wait_quiet("init");
        check_seq("init", base, 11, 0);
        check("init_sel8", 32'(tx_sel[base+8]), 32'd1);
        check("init_addr10", 32'(tx_addr[base+10]), 32'd2);
        check("init_cfg", 32'(cfg_valid_o), 32'd1);
        check("init_busy", 32'(busy_o), 32'd0);

        // Single change: latency, content, busy release after the gap.
        base = tx_sel.size(); rbase = rise_log.size(); dbase = done_log.size();
        set_ch(3, 16'hA5C3);
        c0 = cyc;
        wait_quiet("ch3");
        check("ch3_count", 32'(tx_sel.size() - base), 32'd1);
        if (tx_sel.size() > base) begin
            check("ch3_sel", 32'(tx_sel[base]), 32'd0);
            check("ch3_addr", 32'(tx_addr[base]), 32'd3);
            check("ch3_data", 32'(tx_data[base]), 32'hA5C3);
        end
        if (rise_log.size() > rbase) check("ch3_latency", 32'(rise_log[rbase] - c0), 32'd2);
        if (done_log.size() > dbase)
            check("ch3_busy_fall", 32'(quiet_cyc - done_log[dbase]), 32'(GAP_CYCLES + 1));
        tick(30);
        check("ch3_no_more", 32'(tx_sel.size() - base), 32'd1);

        // Channel 4 changes again while its first write is still in flight.
        base = tx_sel.size();
        set_ch(4, 16'h0F0F);
        wait_accept(base, "ch4");
        tick(3);
        check("ch4_busy_wait", 32'(busy_o), 32'd1);
        check("ch4_pend_clear", 32'(pending_o[4]), 32'd0);
        set_ch(4, 16'h1111);
        tick(1);
        check("ch4_pend_again", 32'(pending_o[4]), 32'd1);
        wait_quiet("ch4");
        check("ch4_count", 32'(tx_sel.size() - base), 32'd2);
        if (tx_sel.size() > base + 1) begin
            check("ch4_addr0", 32'(tx_addr[base]), 32'd4);
            check("ch4_data0", 32'(tx_data[base]), 32'h0F0F);
            check("ch4_addr1", 32'(tx_addr[base+1]), 32'd4);
            check("ch4_data1", 32'(tx_data[base+1]), 32'h1111);
        end

        // Pointer now at 5: channels 9 and 2 change together.
        base = tx_sel.size(); rbase = rise_log.size(); dbase = done_log.size();
        set_ch(9, 16'h9999);
        set_ch(2, 16'h2222);
        wait_quiet("rr");
        check("rr_count", 32'(tx_sel.size() - base), 32'd2);
        if (tx_sel.size() > base + 1) begin
            check("rr_sel0", 32'(tx_sel[base]), 32'd1);
            check("rr_addr0", 32'(tx_addr[base]), 32'd1);
            check("rr_data0", 32'(tx_data[base]), 32'h9999);
            check("rr_sel1", 32'(tx_sel[base+1]), 32'd0);
            check("rr_addr1", 32'(tx_addr[base+1]), 32'd2);
            check("rr_data1", 32'(tx_data[base+1]), 32'h2222);
        end
        if (rise_log.size() > rbase + 1 && done_log.size() > dbase)
            check("rr_gap", 32'(rise_log[rbase+1] - done_log[dbase]), 32'(GAP_CYCLES + 2));

        // Serializer stalls for 50 cycles; a stray done during ISSUE and in IDLE is ignored.
        wr_ready_i = 1'b0;
        base = tx_sel.size(); rbase = rise_log.size();
        set_ch(7, 16'h7777);
        c0 = 0;
        while (rise_log.size() <= rbase && c0 < 50) begin
            tick(1);
            c0++;
        end
        check("stall_valid_rise", 32'(c0 < 50), 32'd1);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) inj_done = 1'b1;
            if (i == 11) inj_done = 1'b0;
            tick(1);
            if (wr_valid_o && wr_data_o == 16'h7777 && wr_addr_o == 3'd7 && !wr_dac_sel_o)
                stable++;
        end
        check("stall_stable", 32'(stable), 32'd50);
        check("stall_no_accept", 32'(tx_sel.size() - base), 32'd0);
        c0 = cyc;
        wr_ready_i = 1'b1;
        tick(1);
        check("stall_accept_count", 32'(tx_sel.size() - base), 32'd1);
        if (tx_sel.size() > base) begin
            check("stall_accept_cycle", 32'(tx_cyc[base]), 32'(c0));
            check("stall_data", 32'(tx_data[base]), 32'h7777);
        end
        check("stall_valid_drop", 32'(wr_valid_o), 32'd0);
        wait_quiet("stall");
        base = tx_sel.size();
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        tick(5);
        check("idle_done_busy", 32'(busy_o), 32'd0);
        check("idle_done_valid", 32'(wr_valid_o), 32'd0);
        check("idle_done_writes", 32'(tx_sel.size() - base), 32'd0);

        // Reset while a write waits for its done pulse.
        base = tx_sel.size();
        set_ch(5, 16'h5555);
        wait_accept(base, "rst");
        tick(3);
        check("rst_mid_busy_before", 32'(busy_o), 32'd1);
        reset = 1'b0;
        tick(1);
        check("rst_mid_valid", 32'(wr_valid_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_cfg", 32'(cfg_valid_o), 32'd0);
        check("rst_mid_pending", 32'(pending_o), 32'h7FF);
        tick(1);
        base = tx_sel.size();
        reset = 1'b1;
        wait_quiet("reload");
        check_seq("reload", base, 11, 0);
        check("reload_data5", 32'(tx_data[base+5]), 32'h5555);
        check("reload_cfg", 32'(cfg_valid_o), 32'd1);

        // Forced refresh of unchanged data.
        base = tx_sel.size();
        force_refresh_i = 1'b1;
        tick(1);
        force_refresh_i = 1'b0;
        check("force_pending", 32'(pending_o), 32'h7FF);
        wait_quiet("force");
        check_seq("force", base, 11, 0);
        check("force_data9", 32'(tx_data[base+9]), 32'h9999);
    endtask

    initial begin
        fork
            model_loop();
        join_none
        run_tests();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcms_dac_update_scheduler.md
Name: lcms_dac_update_scheduler

Overview:
- Sequences bias/reference DAC writes for the LCMS2012 front end (integrator, post-amp, output buffer, VREF, VCMD).
- Keeps a shadow copy of the last value written per channel and detects changed or forced channels.
- Picks pending channels round-robin and hands one word at a time to the existing DAC serial engine over a valid/ready + done handshake.
- Sits between the host configuration registers and the DAC1/DAC2 serializer; everything runs on dac_sm_clk.

Parameters:
- NUM_CH, 11, number of 16-bit DAC channels (2..16).
- CH_PER_DAC, 8, channels per physical DAC device.
- GAP_CYCLES, 4, idle cycles between consecutive writes (minimum SYNC-high time), 1..255.

Ports:
- dac_sm_clk  in  1  state-machine clock (10 MHz).
- reset  in  1  synchronous, active-low reset.
- ch_data_i  in  NUM_CH*16  packed channel values; channel k = bits [16k+15:16k].
- force_refresh_i  in  1  single-cycle pulse; marks every channel pending.
- wr_valid_o  out  1  write request to the serializer.
- wr_ready_i  in  1  serializer can accept a word.
- wr_dac_sel_o  out  1  0 = DAC1, 1 = DAC2 (k / CH_PER_DAC).
- wr_addr_o  out  3  DAC channel address (k % CH_PER_DAC).
- wr_data_o  out  16  value to write.
- wr_done_i  in  1  single-cycle pulse; serial frame finished.
- busy_o  out  1  high in every state except IDLE.
- pending_o  out  NUM_CH  per-channel pending flags.
- cfg_valid_o  out  1  sticky; set after every channel has been written at least once since reset.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE; wr_valid_o=0, wr_dac_sel_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, cfg_valid_o=0.
  - Shadow registers clear to 0; force bits set to all-ones (full initial load).
  - Round-robin pointer goes to 0; written-once mask clears.
  - A write in flight is abandoned; the scheduler does not wait for wr_done_i.
- Pending flag: pending[k] = (ch_data_i[k] != shadow[k]) | force[k]. It is recomputed every cycle and is combinational onto pending_o.
- force_refresh_i sets force[NUM_CH-1:0]. If it coincides with the ISSUE handshake of channel k, force[k] still ends up set (set wins over clear).
- State machine:
  - IDLE: if any pending bit is set -> SELECT next cycle.
  - SELECT (1 cycle):
    - Choose the first pending index at or after the pointer, searching upward and wrapping.
    - Latch k, the data word, the DAC select and the address.
    - Go to ISSUE. If nothing is still pending, go to IDLE.
  - ISSUE: wr_valid_o=1; outputs stay stable until wr_valid_o & wr_ready_i. On that cycle:
    - shadow[k] <= latched data; force[k] cleared; written-once[k] set.
    - pointer <= (k+1) mod NUM_CH.
    - wr_valid_o drops the next cycle; go to WAIT_DONE.
  - WAIT_DONE: stay until wr_done_i -> GAP. A wr_done_i pulse in any other state is ignored.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. If anything is pending, go to SELECT directly instead.
- Data change while a write is in flight:
  - The shadow holds the value latched at SELECT, so the mismatch re-raises pending[k].
  - The channel is rewritten after the other pending channels, per round-robin order.
- cfg_valid_o is set the cycle after written-once is all-ones. It is cleared only by reset.
- Latency, from an input change in IDLE to wr_valid_o: 2 cycles (IDLE -> SELECT -> ISSUE).
- Pointer wrap: after channel NUM_CH-1 is written, the pointer returns to 0.

Test Plan:
- Reset release, all inputs 0, serializer with ready=1 and done 20 cycles after accept:
  - exactly 11 writes, in order k=0..10;
  - dac_sel=0 with addr 0..7, then dac_sel=1 with addr 0..2, all data 0x0000;
  - cfg_valid_o rises after the 11th accept; busy_o falls after the last GAP.
- Idle, then ch_data_i[3] set to 0xA5C3:
  - one write, dac_sel=0, addr=3, data=0xA5C3;
  - wr_valid_o asserts 2 cycles after the change;
  - no further writes.
- Channels 9 and 2 change together while the pointer is at 5:
  - order is 9 (dac_sel=1, addr=1), then 2;
  - each write is separated by at least GAP_CYCLES after its done pulse.
- Hold wr_ready_i=0 for 50 cycles during ISSUE:
  - wr_valid_o and data stay stable the whole time;
  - transfer occurs on the first ready cycle;
  - wr_done_i pulsed in IDLE has no effect.
- Change channel 4 to 0x1111 while channel 4 is in WAIT_DONE (shadow 0x0F0F):
  - pending[4] re-asserts;
  - a second write of 0x1111 follows.
- Reset asserted during WAIT_DONE:
  - next cycle wr_valid_o=0, busy_o=0, cfg_valid_o=0;
  - after release, a full 11-channel reload starts again from k=0.
- force_refresh_i pulsed once the configuration is stable: all 11 channels rewrite with unchanged data.
